// File: rtl/main_fsm.sv
// Multicycle processor main controller.
// Walks each instruction through fetch, decode and the class-specific
// execute/memory/writeback steps, producing the datapath selects and
// enables for the current step. All outputs are combinational from the
// current state and the instruction fields, so they respond in the same cycle.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       BL,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t state;
  state_t next_state;

  // Funct[3:1] only matter to the ALU decoder, not to sequencing.
  logic unused_funct;
  assign unused_funct = ^Funct[3:1];

  // State register; reset forces FETCH at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Sequencing: pick the next step from the current state, the
  // instruction class and whether memory finished its access this cycle.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b00:   next_state = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    next_state = MemReady ? MEMWB : MEMRD;
      MEMWB:    next_state = FETCH;
      MEMWR:    next_state = MemReady ? FETCH : MEMWR;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BRANCH:   next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  // Datapath controls for the current step; everything defaults to 0 and
  // each state raises only what it needs. Reset masks all enables so a
  // store in flight is abandoned immediately.
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    BL        = 1'b0;
    IllegalOp = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IllegalOp = (Op == 2'b11);
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        ALUOp = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        RegW  = 1'b1;
        ALUOp = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        BL        = Funct[4];
      end
      default: begin
      end
    endcase
    if (reset) begin
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      BL        = 1'b0;
      IllegalOp = 1'b0;
      ALUOp     = 1'b0;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: walks each instruction class cycle by cycle
// and compares state and key controls against hand-computed sequences.
module tb_main_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       BL;
  logic       IllegalOp;
  logic [3:0] State;

  int compared;
  int mismatched;

  main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .MemReady  (MemReady),
    .IRWrite   (IRWrite),
    .NextPC    (NextPC),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .BL        (BL),
    .IllegalOp (IllegalOp),
    .State     (State)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset holds FETCH with enables low even if memory reports ready;
  // first FETCH after release drives the PC+4 path and loads the IR.
  task automatic test_reset();
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; MemReady = 1'b1;
    @(negedge clk); #1;
    compared++;
    if (State !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_state: got %0d expected 0", State); end
    compared++;
    if ({IRWrite, NextPC, RegW, MemW, Branch, BL, IllegalOp} !== 7'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_enables: got %b expected 0000000", {IRWrite, NextPC, RegW, MemW, Branch, BL, IllegalOp});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    compared++;
    if ({IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 8'b1101_1010) begin
      mismatched++;
      $display("[TB] FAIL first_fetch: got %b expected 11011010", {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc});
    end
    MemReady = 1'b0;
    @(negedge clk);
  endtask

  // ADD register: FETCH, DECODE, EXECUTER, ALUWB.
  task automatic test_add();
    logic [3:0] es [0:3];
    logic       er [0:3];
    logic       ea [0:3];
    es = '{4'd0, 4'd1, 4'd6, 4'd8};
    er = '{1'b0, 1'b0, 1'b0, 1'b1};
    ea = '{1'b0, 1'b0, 1'b1, 1'b1};
    Op = 2'b00; Funct = 6'b001000; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++;
      if (State !== es[i]) begin mismatched++; $display("[TB] FAIL add_state[%0d]: got %0d expected %0d", i, State, es[i]); end
      compared++;
      if (RegW !== er[i]) begin mismatched++; $display("[TB] FAIL add_regw[%0d]: got %b expected %b", i, RegW, er[i]); end
      compared++;
      if (ALUOp !== ea[i]) begin mismatched++; $display("[TB] FAIL add_aluop[%0d]: got %b expected %b", i, ALUOp, ea[i]); end
      @(negedge clk);
    end
  endtask

  // LDR with two memory wait cycles in MEMRD.
  task automatic test_ldr();
    logic [3:0] es [0:6];
    logic       mr [0:6];
    logic       er [0:6];
    logic [1:0] rs [0:6];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rs = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    Op = 2'b01; Funct = 6'b011001;
    for (int i = 0; i < 7; i++) begin
      MemReady = mr[i];
      #1;
      compared++;
      if (State !== es[i]) begin mismatched++; $display("[TB] FAIL ldr_state[%0d]: got %0d expected %0d", i, State, es[i]); end
      compared++;
      if (RegW !== er[i]) begin mismatched++; $display("[TB] FAIL ldr_regw[%0d]: got %b expected %b", i, RegW, er[i]); end
      compared++;
      if (ResultSrc !== rs[i]) begin mismatched++; $display("[TB] FAIL ldr_resultsrc[%0d]: got %b expected %b", i, ResultSrc, rs[i]); end
      @(negedge clk);
    end
  endtask

  // STR with one memory wait cycle in MEMWR; MemW stays up throughout.
  task automatic test_str();
    logic [3:0] es [0:4];
    logic       mr [0:4];
    logic       ew [0:4];
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    Op = 2'b01; Funct = 6'b011000;
    for (int i = 0; i < 5; i++) begin
      MemReady = mr[i];
      #1;
      compared++;
      if (State !== es[i]) begin mismatched++; $display("[TB] FAIL str_state[%0d]: got %0d expected %0d", i, State, es[i]); end
      compared++;
      if (MemW !== ew[i]) begin mismatched++; $display("[TB] FAIL str_memw[%0d]: got %b expected %b", i, MemW, ew[i]); end
      compared++;
      if (RegW !== 1'b0) begin mismatched++; $display("[TB] FAIL str_regw[%0d]: got %b expected 0", i, RegW); end
      @(negedge clk);
    end
  endtask

  // Branch with link (Funct[4]=1), then plain branch (Funct[4]=0).
  task automatic test_branch();
    logic [3:0] es [0:2];
    logic       eb [0:2];
    logic [5:0] fn [0:1];
    es = '{4'd0, 4'd1, 4'd9};
    eb = '{1'b0, 1'b0, 1'b1};
    fn = '{6'b010000, 6'b000000};
    Op = 2'b10; MemReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      Funct = fn[k];
      for (int i = 0; i < 3; i++) begin
        #1;
        compared++;
        if (State !== es[i]) begin mismatched++; $display("[TB] FAIL br%0d_state[%0d]: got %0d expected %0d", k, i, State, es[i]); end
        compared++;
        if (Branch !== eb[i]) begin mismatched++; $display("[TB] FAIL br%0d_branch[%0d]: got %b expected %b", k, i, Branch, eb[i]); end
        compared++;
        if (BL !== (eb[i] & (k == 0))) begin
          mismatched++;
          $display("[TB] FAIL br%0d_bl[%0d]: got %b expected %b", k, i, BL, eb[i] & (k == 0));
        end
        @(negedge clk);
      end
    end
  endtask

  // Three-cycle fetch stall followed by an illegal Op=11 instruction.
  task automatic test_stall_illegal();
    logic [3:0] es [0:4];
    logic       mr [0:4];
    logic       ei [0:4];
    logic       el [0:4];
    es = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    mr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ei = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    Op = 2'b11; Funct = 6'd0;
    for (int i = 0; i < 5; i++) begin
      MemReady = mr[i];
      #1;
      compared++;
      if (State !== es[i]) begin mismatched++; $display("[TB] FAIL ill_state[%0d]: got %0d expected %0d", i, State, es[i]); end
      compared++;
      if ({IRWrite, NextPC} !== {ei[i], ei[i]}) begin
        mismatched++;
        $display("[TB] FAIL ill_irwrite_nextpc[%0d]: got %b%b expected %b%b", i, IRWrite, NextPC, ei[i], ei[i]);
      end
      compared++;
      if (IllegalOp !== el[i]) begin mismatched++; $display("[TB] FAIL ill_flag[%0d]: got %b expected %b", i, IllegalOp, el[i]); end
      @(negedge clk);
    end
    MemReady = 1'b0;
    #1;
    compared++;
    if (State !== 4'd0 || IllegalOp !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ill_return: got state %0d flag %b expected state 0 flag 0", State, IllegalOp);
    end
    @(negedge clk);
  endtask

  // Reset mid-store must drop MemW and return to FETCH before any clock edge.
  task automatic test_reset_memwr();
    Op = 2'b01; Funct = 6'b011000; MemReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    compared++;
    if (State !== 4'd5 || MemW !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_pre: got state %0d memw %b expected state 5 memw 1", State, MemW);
    end
    #1 reset = 1'b1;
    #1;
    compared++;
    if (State !== 4'd0) begin mismatched++; $display("[TB] FAIL rst_async_state: got %0d expected 0", State); end
    compared++;
    if (MemW !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_async_memw: got %b expected 0", MemW); end
    MemReady = 1'b1;
    #1;
    compared++;
    if ({IRWrite, NextPC} !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_irwrite: got %b%b expected 00", IRWrite, NextPC); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    compared++;
    if (State !== 4'd0 || IRWrite !== 1'b1 || NextPC !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_refetch: got state %0d ir %b pc %b expected state 0 ir 1 pc 1", State, IRWrite, NextPC);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_add();
    test_ldr();
    test_str();
    test_branch();
    test_stall_illegal();
    test_reset_memwr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL provide these ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Op  in  2  instruction class, from the instruction register.
- Funct  in  6  instruction function field, from the instruction register.
- MemReady  in  1  memory completes the current access this cycle.
- IRWrite  out  1  load the instruction register.
- NextPC  out  1  write PC+4 into the PC.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- ALUSrcA  out  1  ALU A select: 0=Rn, 1=PC.
- ALUSrcB  out  2  ALU B select: 00=Rm, 01=ExtImm, 10=constant 4.
- ResultSrc  out  2  result select: 00=ALUOut, 01=read data, 10=ALUResult.
- ALUOp  out  1  ALU decoder enable (data-processing).
- RegW  out  1  register file write.
- MemW  out  1  memory write.
- Branch  out  1  branch taken request (unconditional; condition gating is external).
- BL  out  1  branch-with-link write of R14.
- IllegalOp  out  1  one-cycle flag for unsupported Op.
- State  out  4  current state encoding (debug).
REQ-002 Op and Funct SHALL be treated as stable from DECODE until the next FETCH.

Function
REQ-003 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
REQ-004 Codes 10-15 SHALL transition to FETCH with all enables at 0.
REQ-005 Unlisted select outputs SHALL be 0 and unlisted enables SHALL be 0 in every state.
REQ-006 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- IRWrite=NextPC=MemReady.
- Hold while MemReady=0; go to DECODE when MemReady=1.
REQ-007 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state:
- Op=01 -> MEMADR.
- Op=00 with Funct[5]=0 -> EXECUTER.
- Op=00 with Funct[5]=1 -> EXECUTEI.
- Op=10 -> BRANCH.
- Op=11 -> FETCH, with IllegalOp=1 for that cycle only.
REQ-008 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
REQ-009 MEMRD: AdrSrc=1, ResultSrc=00. Hold while MemReady=0; go to MEMWB when MemReady=1.
REQ-010 MEMWB: ResultSrc=01, RegW=1; then FETCH.
REQ-011 MEMWR: AdrSrc=1, ResultSrc=00.
- MemW=1 held for every MEMWR cycle.
- Hold while MemReady=0; go to FETCH when MemReady=1.
REQ-012 EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1; then ALUWB.
REQ-013 EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1; then ALUWB.
REQ-014 ALUWB: ResultSrc=00, RegW=1, ALUOp=1; then FETCH.
REQ-015 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, BL=Funct[4]; then FETCH.
REQ-016 Latency with MemReady=1 throughout SHALL be:
- Data-processing: 4 cycles.
- LDR: 5 cycles.
- STR: 4 cycles.
- Branch: 3 cycles.
- Illegal: 2 cycles.
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-017 Outputs SHALL be combinational from State, Op, Funct and MemReady, with no registered delay.

Reset
REQ-018 While reset=1, State SHALL be FETCH, and IRWrite, NextPC, RegW, MemW, Branch, BL and IllegalOp SHALL be 0 regardless of MemReady.
REQ-019 Reset asserted in any state, including mid-MEMWR with MemW=1, SHALL drop MemW and move to FETCH immediately, without waiting for a clock edge.
REQ-020 The first FETCH after reset deassertion SHALL behave per REQ-006.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- ADD register (Op=00, Funct=001000), MemReady=1 -> State 0,1,6,8,0; RegW=1 only in state 8; ALUOp=1 in 6 and 8.
- LDR (Op=01, Funct=011001), MemReady=0 for 2 cycles in MEMRD -> State 0,1,2,3,3,3,4,0; RegW=1 only in 4 with ResultSrc=01.
- STR (Op=01, Funct=011000), MemReady=0 for 1 cycle in MEMWR -> State 0,1,2,5,5,0; MemW=1 in both state-5 cycles; RegW never 1.
- BL (Op=10, Funct=010000) -> State 0,1,9,0; Branch=1 and BL=1 in state 9. With Funct=000000, BL=0.
- FETCH with MemReady=0 for 3 cycles -> IRWrite=NextPC=0 for 3 cycles, then 1 for one cycle. Op=11 -> IllegalOp=1 in DECODE only, then back to FETCH.
- reset=1 asynchronously while in MEMWR -> State=0 and MemW=0 before the next clk edge.
